// File: rtl/palm_height_extractor_pkg.sv
// Shared definitions for the palm height extractor: FSM states, output width, geometry defaults.
// PALM_HEIGHT_MINPIX_EN selects the row pixel threshold (see row_threshold).
package palm_height_extractor_pkg;

    localparam int PALM_HEIGHT_W      = 8;
    localparam int DEF_IMG_WIDTH      = 64;
    localparam int DEF_IMG_HEIGHT     = 64;
    localparam int DEF_MIN_ROW_PIXELS = 3;

    localparam logic [PALM_HEIGHT_W-1:0] PALM_HEIGHT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Object pixels a row needs before it counts as a palm row.
    function automatic int row_threshold(input int min_pix);
`ifdef PALM_HEIGHT_MINPIX_EN
        return (min_pix < 1) ? 1 : min_pix;
`else
        return (min_pix < 1) ? 1 : 1;
`endif
    endfunction

endpackage

// File: rtl/palm_height_extractor_row_object_counter.sv
// Counts object pixels in the current row and reports whether the row qualifies as palm.
// With a threshold of 1 the counter collapses to a single sticky flag.
module row_object_counter #(
    parameter int IMG_WIDTH = 64,
    parameter int THRESHOLD = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    input  logic row_start,
    input  logic row_end,
    input  logic object_pixel,
    output logic row_hit
);

    localparam int CNT_W = (THRESHOLD <= 1) ? 1 : $clog2(IMG_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(THRESHOLD);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_base;
    logic [CNT_W-1:0] count_now;

    // count_now includes the pixel on the input, so the row's last pixel is counted.
    always_comb begin
        count_base = row_start ? '0 : count_q;
        count_now  = count_base;
        if (object_pixel && (count_base != CNT_MAX)) begin
            count_now = count_base + CNT_W'(1);
        end
        count_d = count_q;
        if (pix_en) begin
            count_d = row_end ? '0 : count_now;
        end
        row_hit = (count_now >= CNT_THR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/palm_height_extractor.sv
// Measures palm height (topmost to bottommost palm row, inclusive) over a raster-order binary frame.
// Build macro PALM_HEIGHT_MINPIX_EN enables the per-row minimum pixel count.
module palm_height_extractor
    import palm_height_extractor_pkg::*;
#(
    parameter int IMG_WIDTH      = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT     = DEF_IMG_HEIGHT,
    parameter int MIN_ROW_PIXELS = DEF_MIN_ROW_PIXELS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pixel_valid,
    input  logic                     sof,
    input  logic                     object_image,
    output logic [PALM_HEIGHT_W-1:0] palm_height,
    output logic                     height_valid,
    output logic                     frame_error
);

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int HT_W  = ROW_W + 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    state_e                   state_q, state_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic                     found_q, found_d;
    logic [ROW_W-1:0]         top_q, top_d;
    logic [ROW_W-1:0]         bottom_q, bottom_d;
    logic [PALM_HEIGHT_W-1:0] palm_height_q, palm_height_d;
    logic                     height_valid_q, height_valid_d;
    logic                     frame_error_q, frame_error_d;

    logic                     start;
    logic                     accept;
    logic [COL_W-1:0]         cur_col;
    logic [ROW_W-1:0]         cur_row;
    logic                     last_col;
    logic                     last_pix;
    logic                     row_hit;
    logic [HT_W-1:0]          height;

    // A valid sof always restarts at col0,row0, whatever state we are in.
    assign start    = pixel_valid && sof;
    assign accept   = pixel_valid && (sof || (state_q == SCAN));
    assign cur_col  = start ? '0 : col_q;
    assign cur_row  = start ? '0 : row_q;
    assign last_col = (cur_col == COL_LAST);
    assign last_pix = last_col && (cur_row == ROW_LAST);

    row_object_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .THRESHOLD (row_threshold(MIN_ROW_PIXELS))
    ) u_row_counter (
        .clk          (clk),
        .rst          (rst),
        .pix_en       (accept),
        .row_start    (start),
        .row_end      (last_col),
        .object_pixel (object_image),
        .row_hit      (row_hit)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
        end
    end

    always_comb begin
        found_d  = start ? 1'b0 : found_q;
        top_d    = top_q;
        bottom_d = bottom_q;
        if (accept && last_col && row_hit) begin
            if (!found_d) begin
                top_d = cur_row;
            end
            bottom_d = cur_row;
            found_d  = 1'b1;
        end
    end

    // Height is taken from the tracking values including the final row, so the
    // result lands in the output register on the same edge the last pixel is accepted.
    always_comb begin
        height = '0;
        if (found_d) begin
            height = {1'b0, bottom_d} - {1'b0, top_d} + HT_W'(1);
        end
        palm_height_d = palm_height_q;
        if (accept && last_pix) begin
            if (height > HT_W'(PALM_HEIGHT_MAX)) begin
                palm_height_d = PALM_HEIGHT_MAX;
            end else begin
                palm_height_d = PALM_HEIGHT_W'(height);
            end
        end
        height_valid_d = accept && last_pix;
        frame_error_d  = start && (state_q == SCAN);
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = last_pix ? DONE : SCAN;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            col_q          <= '0;
            row_q          <= '0;
            found_q        <= 1'b0;
            top_q          <= '0;
            bottom_q       <= '0;
            palm_height_q  <= '0;
            height_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            found_q        <= found_d;
            top_q          <= top_d;
            bottom_q       <= bottom_d;
            palm_height_q  <= palm_height_d;
            height_valid_q <= height_valid_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign palm_height  = palm_height_q;
    assign height_valid = height_valid_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_palm_height_extractor.sv
// Directed bench for palm_height_extractor: 8x8 frames plus a 2x300 instance for saturation.
module tb_palm_height_extractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pixel_valid = 1'b0;
    logic       sof = 1'b0;
    logic       object_image = 1'b0;
    logic [7:0] palm_height;
    logic       height_valid;
    logic       frame_error;

    logic       pv2 = 1'b0;
    logic       sof2 = 1'b0;
    logic       obj2 = 1'b0;
    logic [7:0] ph2;
    logic       hv2;
    logic       fe2;

    int checks = 0;
    int failures = 0;
    int hv_cnt = 0;
    int fe_cnt = 0;

    always #5 clk = ~clk;

    palm_height_extractor #(
        .IMG_WIDTH      (8),
        .IMG_HEIGHT     (8),
        .MIN_ROW_PIXELS (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_valid  (pixel_valid),
        .sof          (sof),
        .object_image (object_image),
        .palm_height  (palm_height),
        .height_valid (height_valid),
        .frame_error  (frame_error)
    );

    palm_height_extractor #(
        .IMG_WIDTH      (2),
        .IMG_HEIGHT     (300),
        .MIN_ROW_PIXELS (2)
    ) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .pixel_valid  (pv2),
        .sof          (sof2),
        .object_image (obj2),
        .palm_height  (ph2),
        .height_valid (hv2),
        .frame_error  (fe2)
    );

    always @(negedge clk) begin
        if (height_valid) hv_cnt++;
        if (frame_error) fe_cnt++;
    end

    function automatic logic [63:0] make_rows(input int r0, input int r1, input logic [7:0] bits);
        logic [63:0] img;
        img = '0;
        for (int r = r0; r <= r1; r++) img[r*8 +: 8] = bits;
        return img;
    endfunction

    task automatic put_pixel(input logic o, input logic s);
        @(negedge clk);
        pixel_valid = 1'b1;
        sof = s;
        object_image = o;
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        sof = 1'b0;
        object_image = 1'b0;
    endtask

    task automatic send_pixels(input logic [63:0] img, input int from, input int to,
                               input int max_gap, input logic sof_first);
        for (int p = from; p <= to; p++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            put_pixel(img[p], (p == from) && sof_first);
        end
    endtask

    task automatic send_sat(input int r0, input int r1);
        for (int p = 0; p < 600; p++) begin
            int r;
            r = p / 2;
            @(negedge clk);
            pv2 = 1'b1;
            sof2 = (p == 0);
            obj2 = (r >= r0) && (r <= r1);
            @(posedge clk);
            #1;
            pv2 = 1'b0;
            sof2 = 1'b0;
            obj2 = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (palm_height !== 8'd0) begin failures++; $display("FAIL reset_height: got %0d expected 0", palm_height); end
        checks++; if (height_valid !== 1'b0) begin failures++; $display("FAIL reset_hv: got %b expected 0", height_valid); end
        checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_fe: got %b expected 0", frame_error); end
        checks++; if (ph2 !== 8'd0) begin failures++; $display("FAIL reset_sat_height: got %0d expected 0", ph2); end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: palm_height=%0d height_valid=%b frame_error=%b", palm_height, height_valid, frame_error);
    endtask

    task automatic test_basic;
        logic [63:0] img;
        int hv_base;
        img = make_rows(2, 6, 8'h3C);
        hv_base = hv_cnt;
        send_pixels(img, 0, 62, 0, 1'b1);
        checks++; if (height_valid !== 1'b0) begin failures++; $display("FAIL basic_early_hv: got %b expected 0", height_valid); end
        put_pixel(img[63], 1'b0);
        checks++; if (height_valid !== 1'b1) begin failures++; $display("FAIL basic_hv_latency: got %b expected 1", height_valid); end
        checks++; if (palm_height !== 8'd5) begin failures++; $display("FAIL basic_height: got %0d expected 5", palm_height); end
        @(posedge clk); #1;
        checks++; if (height_valid !== 1'b0) begin failures++; $display("FAIL basic_hv_width: got %b expected 0", height_valid); end
        checks++; if (hv_cnt - hv_base !== 1) begin failures++; $display("FAIL basic_hv_count: got %0d expected 1", hv_cnt - hv_base); end
        $display("basic: rows 2..6 x4 -> palm_height=%0d", palm_height);
    endtask

    task automatic test_thresholds;
        logic [63:0] img;
        int exp_h;
        send_pixels('0, 0, 63, 0, 1'b1);
        checks++; if (height_valid !== 1'b1 || palm_height !== 8'd0) begin failures++; $display("FAIL zero_frame: got hv=%b h=%0d expected hv=1 h=0", height_valid, palm_height); end
        $display("zero frame -> palm_height=%0d", palm_height);

        img = make_rows(3, 3, 8'h03);
`ifdef PALM_HEIGHT_MINPIX_EN
        exp_h = 0;
`else
        exp_h = 1;
`endif
        send_pixels(img, 0, 63, 0, 1'b1);
        checks++; if (palm_height !== 8'(exp_h)) begin failures++; $display("FAIL sparse_row: got %0d expected %0d", palm_height, exp_h); end
        $display("row 3 x2 -> palm_height=%0d", palm_height);

        img = make_rows(4, 4, 8'h07);
        send_pixels(img, 0, 63, 0, 1'b1);
        checks++; if (palm_height !== 8'd1) begin failures++; $display("FAIL exact_threshold_row: got %0d expected 1", palm_height); end
        $display("row 4 x3 -> palm_height=%0d", palm_height);

        img = make_rows(0, 0, 8'h07) | make_rows(7, 7, 8'hE0);
        send_pixels(img, 0, 63, 0, 1'b1);
        checks++; if (palm_height !== 8'd8) begin failures++; $display("FAIL edge_rows: got %0d expected 8", palm_height); end
        $display("rows 0 and 7 x3 -> palm_height=%0d", palm_height);

        img = make_rows(3, 3, 8'h07);
        send_pixels(img, 0, 63, 0, 1'b1);
        checks++; if (palm_height !== 8'd1) begin failures++; $display("FAIL single_row: got %0d expected 1", palm_height); end
    endtask

    task automatic test_early_sof;
        logic [63:0] full;
        int fe_base;
        int hv_base;
        full = '1;
        send_pixels(full, 0, 29, 0, 1'b1);
        fe_base = fe_cnt;
        hv_base = hv_cnt;
        put_pixel(full[0], 1'b1);
        checks++; if (frame_error !== 1'b1) begin failures++; $display("FAIL early_sof_fe: got %b expected 1", frame_error); end
        checks++; if (palm_height !== 8'd1) begin failures++; $display("FAIL early_sof_hold: got %0d expected 1", palm_height); end
        send_pixels(full, 1, 63, 0, 1'b0);
        checks++; if (hv_cnt - hv_base !== 0) begin failures++; $display("FAIL early_sof_no_hv: got %0d pulses expected 0", hv_cnt - hv_base); end
        checks++; if (height_valid !== 1'b1 || palm_height !== 8'd8) begin failures++; $display("FAIL early_sof_next: got hv=%b h=%0d expected hv=1 h=8", height_valid, palm_height); end
        checks++; if (fe_cnt - fe_base !== 1) begin failures++; $display("FAIL early_sof_fe_count: got %0d expected 1", fe_cnt - fe_base); end
        $display("early sof: restart full frame -> palm_height=%0d", palm_height);
    endtask

    task automatic test_gaps;
        logic [63:0] img;
        int hv_base;
        int fe_base;
        img = make_rows(2, 6, 8'h3C);
        @(posedge clk); #1;
        hv_base = hv_cnt;
        fe_base = fe_cnt;
        repeat (5) put_pixel(1'b1, 1'b0);
        @(posedge clk); #1;
        checks++; if (hv_cnt !== hv_base || palm_height !== 8'd8) begin failures++; $display("FAIL pre_sof_ignored: got pulses=%0d h=%0d expected 0 and 8", hv_cnt - hv_base, palm_height); end
        send_pixels(img, 0, 19, 5, 1'b1);
        @(negedge clk); sof = 1'b1;
        @(posedge clk); #1; sof = 1'b0;
        send_pixels(img, 20, 63, 5, 1'b0);
        checks++; if (height_valid !== 1'b1 || palm_height !== 8'd5) begin failures++; $display("FAIL gap_frame: got hv=%b h=%0d expected hv=1 h=5", height_valid, palm_height); end
        checks++; if (fe_cnt !== fe_base) begin failures++; $display("FAIL sof_without_valid: got %0d error pulses expected 0", fe_cnt - fe_base); end
        $display("gapped frame -> palm_height=%0d", palm_height);
    endtask

    task automatic test_back_to_back;
        logic [63:0] img_a;
        logic [63:0] img_b;
        int fe_base;
        img_a = make_rows(2, 6, 8'h3C);
        img_b = make_rows(1, 2, 8'hFF);
        fe_base = fe_cnt;
        send_pixels(img_a, 0, 63, 0, 1'b1);
        checks++; if (height_valid !== 1'b1 || palm_height !== 8'd5) begin failures++; $display("FAIL b2b_first: got hv=%b h=%0d expected hv=1 h=5", height_valid, palm_height); end
        send_pixels(img_b, 0, 63, 0, 1'b1);
        checks++; if (height_valid !== 1'b1 || palm_height !== 8'd2) begin failures++; $display("FAIL b2b_second: got hv=%b h=%0d expected hv=1 h=2", height_valid, palm_height); end
        checks++; if (fe_cnt !== fe_base) begin failures++; $display("FAIL b2b_no_error: got %0d error pulses expected 0", fe_cnt - fe_base); end
        $display("back to back: second frame -> palm_height=%0d", palm_height);
    endtask

    task automatic test_async_reset;
        logic [63:0] img;
        int hv_base;
        img = make_rows(2, 6, 8'h3C);
        send_pixels(img, 0, 39, 0, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (palm_height !== 8'd0 || height_valid !== 1'b0 || frame_error !== 1'b0) begin failures++; $display("FAIL async_reset: got h=%0d hv=%b fe=%b expected 0 0 0", palm_height, height_valid, frame_error); end
        @(negedge clk); rst = 1'b0;
        hv_base = hv_cnt;
        send_pixels(img, 40, 63, 0, 1'b0);
        @(posedge clk); #1;
        checks++; if (hv_cnt !== hv_base) begin failures++; $display("FAIL reset_discards_frame: got %0d pulses expected 0", hv_cnt - hv_base); end
        send_pixels(img, 0, 63, 0, 1'b1);
        checks++; if (height_valid !== 1'b1 || palm_height !== 8'd5) begin failures++; $display("FAIL post_reset_frame: got hv=%b h=%0d expected hv=1 h=5", height_valid, palm_height); end
        $display("after async reset: palm_height=%0d", palm_height);
    endtask

    task automatic test_saturation;
        send_sat(0, 299);
        checks++; if (hv2 !== 1'b1 || ph2 !== 8'd255) begin failures++; $display("FAIL sat_full: got hv=%b h=%0d expected hv=1 h=255", hv2, ph2); end
        $display("300 rows full -> palm_height=%0d", ph2);
        send_sat(1, 254);
        checks++; if (ph2 !== 8'd254) begin failures++; $display("FAIL sat_254: got %0d expected 254", ph2); end
        send_sat(0, 255);
        checks++; if (ph2 !== 8'd255) begin failures++; $display("FAIL sat_256: got %0d expected 255", ph2); end
        send_sat(10, 10);
        checks++; if (ph2 !== 8'd1) begin failures++; $display("FAIL sat_single: got %0d expected 1", ph2); end
        $display("tall frame row 10 only -> palm_height=%0d", ph2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_thresholds();
        test_early_sof();
        test_gaps();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
